// File: rtl/cplx_alu_arbiter.sv
// rtl/cplx_alu_arbiter.sv - round-robin arbiter sharing a 2-stage complex add/multiply datapath
// Optional: CPLX_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module cplx_alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int LAT   = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a_re,
    input  logic [NREQ*WIDTH-1:0] req_a_im,
    input  logic [NREQ*WIDTH-1:0] req_c_re,
    input  logic [NREQ*WIDTH-1:0] req_c_im,
    output logic [WIDTH-1:0]      dp_a_re,
    output logic [WIDTH-1:0]      dp_a_im,
    output logic [WIDTH-1:0]      dp_c_re,
    output logic [WIDTH-1:0]      dp_c_im,
    input  logic [WIDTH-1:0]      dp_sum_re,
    input  logic [WIDTH-1:0]      dp_sum_im,
    input  logic [WIDTH-1:0]      dp_prod_re,
    input  logic [WIDTH-1:0]      dp_prod_im,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum_re,
    output logic [WIDTH-1:0]      rsp_sum_im,
    output logic [WIDTH-1:0]      rsp_prod_re,
    output logic [WIDTH-1:0]      rsp_prod_im,
    input  logic                  halt,
    output logic                  idle
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            issue_en;
    logic            grant_fire;
    logic [IDW-1:0]  grant_id;
    logic [LAT-1:0]  tag_v;
    logic [IDW-1:0]  tag_id [LAT];
    logic            pipe_empty;
    logic [WIDTH-1:0] a_re_q, a_im_q, c_re_q, c_im_q;

    // Reset is folded in so no grant can appear while the unit is held in reset.
    assign issue_en = rst_n && (state_q == ST_RUN) && !halt;

`ifdef CPLX_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_fire = 1'b0;
        grant_id   = '0;
        if (issue_en) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[k]) begin
                    grant_fire = 1'b1;
                    grant_id   = IDW'(k);
                end
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr;
    int             rr_idx;

    // Descending scan so the candidate closest to the pointer is the last one written.
    always_comb begin
        grant_fire = 1'b0;
        grant_id   = '0;
        rr_idx     = 0;
        if (issue_en) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                rr_idx = (int'(rr_ptr) + k) % NREQ;
                if (req_valid[rr_idx]) begin
                    grant_fire = 1'b1;
                    grant_id   = IDW'(rr_idx);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_fire) begin
            rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end
`endif

    assign req_ready = grant_fire ? (NREQ'(1) << grant_id) : '0;

    // Operands follow the grant; between grants the last issued operands are held.
    always_comb begin
        dp_a_re = a_re_q;
        dp_a_im = a_im_q;
        dp_c_re = c_re_q;
        dp_c_im = c_im_q;
        if (grant_fire) begin
            dp_a_re = req_a_re[int'(grant_id)*WIDTH +: WIDTH];
            dp_a_im = req_a_im[int'(grant_id)*WIDTH +: WIDTH];
            dp_c_re = req_c_re[int'(grant_id)*WIDTH +: WIDTH];
            dp_c_im = req_c_im[int'(grant_id)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_re_q <= '0;
            a_im_q <= '0;
            c_re_q <= '0;
            c_im_q <= '0;
        end else if (grant_fire) begin
            a_re_q <= dp_a_re;
            a_im_q <= dp_a_im;
            c_re_q <= dp_c_re;
            c_im_q <= dp_c_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= grant_fire;
            tag_id[0] <= grant_id;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign pipe_empty  = (tag_v == '0);
    assign rsp_valid   = tag_v[LAT-1];
    assign rsp_id      = tag_id[LAT-1];
    assign rsp_sum_re  = dp_sum_re;
    assign rsp_sum_im  = dp_sum_im;
    assign rsp_prod_re = dp_prod_re;
    assign rsp_prod_im = dp_prod_im;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (halt)       state_d = ST_DRAIN;
            ST_DRAIN:  if (pipe_empty) state_d = ST_HALTED;
            ST_HALTED: if (!halt)      state_d = ST_RUN;
            default:                   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            idle    <= 1'b0;
        end else begin
            state_q <= state_d;
            idle    <= (state_d == ST_HALTED);
        end
    end

endmodule

// File: tb/tb_cplx_alu_arbiter.sv
// tb/tb_cplx_alu_arbiter.sv - scoreboard bench for cplx_alu_arbiter with a behavioural datapath
module tb_cplx_alu_arbiter;
    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int LAT   = 2;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a_re, req_a_im, req_c_re, req_c_im;
    logic [WIDTH-1:0]      dp_a_re, dp_a_im, dp_c_re, dp_c_im;
    logic [WIDTH-1:0]      dp_sum_re, dp_sum_im, dp_prod_re, dp_prod_im;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum_re, rsp_sum_im, rsp_prod_re, rsp_prod_im;
    logic                  halt;
    logic                  idle;

    logic [WIDTH-1:0] a_re [NREQ];
    logic [WIDTH-1:0] a_im [NREQ];
    logic [WIDTH-1:0] c_re [NREQ];
    logic [WIDTH-1:0] c_im [NREQ];

    always_comb begin
        req_a_re = '0;
        req_a_im = '0;
        req_c_re = '0;
        req_c_im = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a_re[i*WIDTH +: WIDTH] = a_re[i];
            req_a_im[i*WIDTH +: WIDTH] = a_im[i];
            req_c_re[i*WIDTH +: WIDTH] = c_re[i];
            req_c_im[i*WIDTH +: WIDTH] = c_im[i];
        end
    end

    cplx_alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a_re(req_a_re), .req_a_im(req_a_im), .req_c_re(req_c_re), .req_c_im(req_c_im),
        .dp_a_re(dp_a_re), .dp_a_im(dp_a_im), .dp_c_re(dp_c_re), .dp_c_im(dp_c_im),
        .dp_sum_re(dp_sum_re), .dp_sum_im(dp_sum_im), .dp_prod_re(dp_prod_re), .dp_prod_im(dp_prod_im),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_sum_re(rsp_sum_re), .rsp_sum_im(rsp_sum_im), .rsp_prod_re(rsp_prod_re), .rsp_prod_im(rsp_prod_im),
        .halt(halt), .idle(idle)
    );

    // {sum_re, sum_im, prod_re, prod_im}, wrapped to WIDTH bits
    function automatic logic [4*WIDTH-1:0] cplx(input logic [WIDTH-1:0] ar, ai, cr, ci);
        int xar, xai, xcr, xci;
        logic [WIDTH-1:0] sr, si, pr, pi;
        xar = $signed(ar); xai = $signed(ai); xcr = $signed(cr); xci = $signed(ci);
        sr = WIDTH'(xar + xcr);
        si = WIDTH'(xai + xci);
        pr = WIDTH'(xar * xcr - xai * xci);
        pi = WIDTH'(xar * xci + xai * xcr);
        return {sr, si, pr, pi};
    endfunction

    // Two-stage datapath: registered operands, then registered results.
    logic [WIDTH-1:0] s1_ar, s1_ai, s1_cr, s1_ci;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ar <= '0; s1_ai <= '0; s1_cr <= '0; s1_ci <= '0;
            {dp_sum_re, dp_sum_im, dp_prod_re, dp_prod_im} <= '0;
        end else begin
            s1_ar <= dp_a_re; s1_ai <= dp_a_im; s1_cr <= dp_c_re; s1_ci <= dp_c_im;
            {dp_sum_re, dp_sum_im, dp_prod_re, dp_prod_im} <= cplx(s1_ar, s1_ai, s1_cr, s1_ci);
        end
    end

    typedef struct {
        int               id;
        int               due;
        logic [4*WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference state: pointer, mode (0 run, 1 drain, 2 halted), grant history, last operands.
    int               m_ptr;
    int               m_mode;
    bit               m_g1, m_g2;
    logic [4*WIDTH-1:0] m_ops;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(e.due));
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_data", {rsp_sum_re, rsp_sum_im, rsp_prod_re, rsp_prod_im}, e.data);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                check("rsp_missing", 64'(rsp_valid), 64'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        int g;
        int idx;
        logic [NREQ-1:0] exp_rdy;
        exp_t e;
        @(negedge clk);
        g = -1;
        if (m_mode == 0 && !halt) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("idle", 64'(idle), 64'(m_mode == 2));
        if (g >= 0) begin
            m_ops  = {a_re[g], a_im[g], c_re[g], c_im[g]};
            e.id   = g;
            e.due  = cyc + LAT;
            e.data = cplx(a_re[g], a_im[g], c_re[g], c_im[g]);
            exp_q.push_back(e);
        end
        check("dp_ops", {dp_a_re, dp_a_im, dp_c_re, dp_c_im}, m_ops);
        case (m_mode)
            0: if (halt) m_mode = 1;
            1: if (!m_g1 && !m_g2) m_mode = 2;
            default: if (!halt) m_mode = 0;
        endcase
        if (g >= 0) begin
`ifdef CPLX_ARB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (g + 1) % NREQ;
`endif
        end
        m_g2 = m_g1;
        m_g1 = (g >= 0);
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NREQ; i++) begin
            a_re[i] = WIDTH'($urandom);
            a_im[i] = WIDTH'($urandom);
            c_re[i] = WIDTH'($urandom);
            c_im[i] = WIDTH'($urandom);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        m_ptr = 0; m_mode = 0; m_g1 = 1'b0; m_g2 = 1'b0; m_ops = '0;
        req_valid = '1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_idle", 64'(idle), 64'd0);
        check("rst_dp_ops", {dp_a_re, dp_a_im, dp_c_re, dp_c_im}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '0;
    endtask

    initial begin
        req_valid = '0;
        halt = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_re[i] = '0; a_im[i] = '0; c_re[i] = '0; c_im[i] = '0;
        end
        @(posedge clk);
        #1;
        do_reset();
        repeat (2) step();

        // Single requester 2: A=(3,4), C=(1,2) -> sum (4,6), prod (-5,10)
        a_re[2] = 16'd3; a_im[2] = 16'd4; c_re[2] = 16'd1; c_im[2] = 16'd2;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (3) step();

        // All valid from pointer 0: grants rotate 0,1,2,3,...
        do_reset();
        req_valid = '1;
        repeat (8) begin
            randomize_ops();
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Move pointer to 2, then requesters 1 and 3 contend; 0 joins later
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1010;
        repeat (3) begin
            randomize_ops();
            step();
        end
        req_valid = 4'b1011;
        repeat (NREQ) step();
        req_valid = '0;
        repeat (3) step();

        // Halt with two ops in flight, then release
        req_valid = '1;
        repeat (2) begin
            randomize_ops();
            step();
        end
        halt = 1'b1;
        repeat (6) step();
        halt = 1'b0;
        repeat (3) step();

        // Halt released during drain still passes through HALTED
        halt = 1'b1;
        step();
        halt = 1'b0;
        repeat (6) step();

        // Reset one cycle after a grant discards the in-flight op
        req_valid = '1;
        randomize_ops();
        step();
        do_reset();
        req_valid = '1;
        repeat (3) step();
        req_valid = '0;
        repeat (3) step();

        // Randomized traffic with occasional halt pulses
        for (int n = 0; n < 400; n++) begin
            randomize_ops();
            req_valid = NREQ'($urandom);
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            step();
        end
        halt = 1'b0;
        req_valid = '0;
        repeat (6) step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
